// File: rtl/tensor_stream_packer.sv
// Tensor stream packer: collects a CH*H*W feature map streamed one element per
// cycle (channel-major) into a flat packed vector. The vector is held stable
// with out_valid until the downstream stage accepts it.
module tensor_stream_packer #(
  parameter int unsigned CH    = 1,
  parameter int unsigned H     = 1,
  parameter int unsigned W     = 1,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned DIM  = CH * H * W,
  localparam int unsigned CW   = ($clog2(DIM + 1) > 1) ? $clog2(DIM + 1) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [DIM*WIDTH-1:0]    out_vec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    frame_err,
  output logic [CW-1:0]           fill_count
);

  typedef enum logic [0:0] {StFill, StHold} state_e;

  localparam logic [CW-1:0] LastIdx = CW'(DIM - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        fill_count_q, fill_count_d;
  logic [DIM*WIDTH-1:0] out_vec_q, out_vec_d;
  logic                 frame_err_q, frame_err_d;
  logic                 accept;

  // Ready is decoded from registered state and masked while reset is asserted.
  assign in_ready   = (state_q == StFill) && !rst;
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == StHold);
  assign out_vec    = out_vec_q;
  assign frame_err  = frame_err_q;
  assign fill_count = fill_count_q;

  // Next-state logic: slot writes and framing checks in FILL, release in HOLD.
  always_comb begin
    state_d      = state_q;
    fill_count_d = fill_count_q;
    out_vec_d    = out_vec_q;
    frame_err_d  = 1'b0;
    unique case (state_q)
      StFill: begin
        if (accept) begin
          for (int unsigned i = 0; i < DIM; i++) begin
            if (fill_count_q == CW'(i)) begin
              out_vec_d[i*WIDTH +: WIDTH] = in_data;
            end
          end
          if (fill_count_q == LastIdx) begin
            // Frame complete; a missing last marker is flagged but data still delivered.
            state_d      = StHold;
            fill_count_d = '0;
            frame_err_d  = !in_last;
          end else if (in_last) begin
            // Early last: drop the partial frame and restart counting.
            fill_count_d = '0;
            frame_err_d  = 1'b1;
          end else begin
            fill_count_d = fill_count_q + CW'(1);
          end
        end
      end
      StHold: begin
        // No bypass: the new frame starts accepting the cycle after the handshake.
        if (out_ready) begin
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StFill;
      fill_count_q <= '0;
      out_vec_q    <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_count_q <= fill_count_d;
      out_vec_q    <= out_vec_d;
      frame_err_q  <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_tensor_stream_packer.sv
// Bench for tensor_stream_packer (CH=2, H=2, W=2, WIDTH=16): directed frames plus
// randomized traffic checked every cycle against a frame-level reference model.
module tb_tensor_stream_packer;

  localparam int CH = 2;
  localparam int H = 2;
  localparam int W = 2;
  localparam int WIDTH = 16;
  localparam int DIM = CH * H * W;
  localparam int CW = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic signed [WIDTH-1:0] in_data = '0;
  logic                    in_valid = 1'b0;
  logic                    in_last = 1'b0;
  logic                    in_ready;
  logic [DIM*WIDTH-1:0]    out_vec;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic                    frame_err;
  logic [CW-1:0]           fill_count;

  int checks = 0;
  int failures = 0;

  // Reference model: frame buffer, elements received so far, holding flag, error pulse.
  logic [WIDTH-1:0] m_mem [DIM];
  int               m_count;
  bit               m_hold;
  bit               m_err;

  localparam logic [DIM*WIDTH-1:0] FirstFrame = 128'h0008_0007_0006_0005_0004_0003_0002_0001;

  tensor_stream_packer #(
    .CH   (CH),
    .H    (H),
    .W    (W),
    .WIDTH(WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_vec   (out_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DIM*WIDTH-1:0] act,
                     input logic [DIM*WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DIM*WIDTH-1:0] model_vec();
    logic [DIM*WIDTH-1:0] v;
    for (int i = 0; i < DIM; i++) v[i*WIDTH +: WIDTH] = m_mem[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DIM; i++) m_mem[i] = '0;
    m_count = 0;
    m_hold  = 1'b0;
    m_err   = 1'b0;
  endtask

  // Compare every DUT output against the model.
  task automatic compare_all();
    chk("in_ready", {127'b0, in_ready}, {127'b0, !m_hold});
    chk("out_valid", {127'b0, out_valid}, {127'b0, m_hold});
    chk("fill_count", {124'b0, fill_count}, 128'(m_count));
    chk("frame_err", {127'b0, frame_err}, {127'b0, m_err});
    chk("out_vec", out_vec, model_vec());
  endtask

  // One clock: drive inputs, advance the model at the edge, compare at the falling edge.
  task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit l, input bit ordy);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    @(posedge clk);
    m_err = 1'b0;
    if (m_hold) begin
      if (ordy) m_hold = 1'b0;
    end else if (v) begin
      m_mem[m_count] = d;
      if (m_count == DIM - 1) begin
        m_hold  = 1'b1;
        m_err   = !l;
        m_count = 0;
      end else if (l) begin
        m_err   = 1'b1;
        m_count = 0;
      end else begin
        m_count++;
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] base, input bit with_last);
    for (int i = 0; i < DIM; i++) cycle(1'b1, base + WIDTH'(i), with_last && (i == DIM - 1), 1'b0);
  endtask

  initial begin
    int accepted;
    int guard;
    bit v;
    bit l;
    model_reset();

    // Reset state.
    @(negedge clk);
    chk("rst_in_ready", {127'b0, in_ready}, 128'd0);
    chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_fill_count", {124'b0, fill_count}, 128'd0);
    chk("rst_out_vec", out_vec, '0);
    chk("rst_frame_err", {127'b0, frame_err}, 128'd0);
    rst = 1'b0;
    #1 compare_all();

    // Basic frame, then hold with in_valid asserted for 20 cycles.
    send_frame(16'h0001, 1'b1);
    chk("basic_valid", {127'b0, out_valid}, 128'd1);
    chk("basic_lo", {112'b0, out_vec[15:0]}, 128'h0001);
    chk("basic_hi", {112'b0, out_vec[127:112]}, 128'h0008);
    for (int i = 0; i < 20; i++) cycle(1'b1, WIDTH'($urandom), 1'($urandom), 1'b0);
    chk("hold_stable", out_vec, FirstFrame);
    chk("hold_in_ready", {127'b0, in_ready}, 128'd0);

    // Release and back-to-back frame.
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("release_valid", {127'b0, out_valid}, 128'd0);
    chk("release_ready", {127'b0, in_ready}, 128'd1);
    send_frame(16'h8000, 1'b1);
    chk("second_hi", {112'b0, out_vec[127:112]}, 128'h8007);
    chk("second_lo", {112'b0, out_vec[15:0]}, 128'h8000);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Bubbles: same frame as the first, ~50% idle, random out_ready ignored in FILL.
    accepted = 0;
    guard = 0;
    while (accepted < DIM && guard < 1000) begin
      v = 1'($urandom);
      cycle(v, WIDTH'(accepted + 1), accepted == DIM - 1, 1'($urandom));
      if (v) accepted++;
      guard++;
    end
    chk("bubble_done", 128'(accepted), 128'(DIM));
    chk("bubble_vec", out_vec, FirstFrame);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Early last on the 5th element.
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h00a0 + WIDTH'(i), i == 4, 1'b0);
    chk("early_err", {127'b0, frame_err}, 128'd1);
    chk("early_fill", {124'b0, fill_count}, 128'd0);
    chk("early_valid", {127'b0, out_valid}, 128'd0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("early_err_clear", {127'b0, frame_err}, 128'd0);
    send_frame(16'h0100, 1'b1);
    chk("after_early_hi", {112'b0, out_vec[127:112]}, 128'h0107);
    chk("after_early_err", {127'b0, frame_err}, 128'd0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Missing last: frame still delivered, error flagged once.
    send_frame(16'h0200, 1'b0);
    chk("missing_err", {127'b0, frame_err}, 128'd1);
    chk("missing_valid", {127'b0, out_valid}, 128'd1);
    chk("missing_lo", {112'b0, out_vec[15:0]}, 128'h0200);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("missing_err_pulse", {127'b0, frame_err}, 128'd0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      l = (m_count == DIM - 1) ? ($urandom_range(7) != 0) : ($urandom_range(15) == 0);
      cycle($urandom_range(3) != 0, WIDTH'($urandom), l, $urandom_range(2) == 0);
    end

    // Async reset mid-frame with three elements accepted.
    guard = 0;
    while (m_hold && guard < 10) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      guard++;
    end
    while (m_count != 0 && guard < 20) begin
      cycle(1'b1, 16'h0300, 1'b1, 1'b0);
      guard++;
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0301 + WIDTH'(i), 1'b0, 1'b0);
    chk("pre_reset_fill", {124'b0, fill_count}, 128'd3);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_fill", {124'b0, fill_count}, 128'd0);
    chk("arst_in_ready", {127'b0, in_ready}, 128'd0);
    chk("arst_vec", out_vec, '0);
    chk("arst_valid", {127'b0, out_valid}, 128'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1 compare_all();

    // Async reset during HOLD.
    send_frame(16'h0400, 1'b1);
    chk("pre_reset_hold", {127'b0, out_valid}, 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("hrst_valid", {127'b0, out_valid}, 128'd0);
    chk("hrst_in_ready", {127'b0, in_ready}, 128'd0);
    chk("hrst_fill", {124'b0, fill_count}, 128'd0);
    chk("hrst_vec", out_vec, '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1 compare_all();
    send_frame(16'h0500, 1'b1);
    chk("final_hi", {112'b0, out_vec[127:112]}, 128'h0507);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
